// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: LFSR width, Galois tap mask, default seed, FSM encodings.
// The step helper is the x^32 + x^22 + x^2 + x + 1 Galois shift used by both LFSRs.
package prbs_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] POLY_TAPS = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SEED_DFLT = 32'h0000_0001;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY_TAPS : '0);
  endfunction
endpackage

// File: rtl/prbs32_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step; load has priority over step.
// Output is bit 0 of the current state, so it is a registered value.
module prbs32_lfsr
  import prbs_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = SEED_DFLT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Load,
  input  logic [LFSR_W-1:0] LoadVal,
  input  logic              Step,
  output logic              Out
);
  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = LoadVal;
    end else if (Step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign Out = state_q[0];
endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS bit-error test sequencer: seeds generator and checker, streams Length bits,
// counts returned bits and mismatches, then reports a pass/fail verdict.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
  parameter int          CNT_W        = 16,
  parameter int          DRAIN_TO     = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic             SeedLoad,
  input  logic [31:0]      Seed,
  input  logic [CNT_W-1:0] Length,
  output logic             TxValid,
  output logic             TxBit,
  input  logic             RxValid,
  input  logic             RxBit,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] ErrCnt,
  output logic [CNT_W-1:0] RxCnt
);
  localparam int DRAIN_W = $clog2(DRAIN_TO) + 1;

  logic [1:0]         state_q, state_d;
  logic [31:0]        seed_q, seed_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               pass_q, pass_d;

  logic        start_ok, rx_ok, gen_bit, chk_bit;
  logic [31:0] seed_in, load_val;

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    len_d     = len_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    drain_d   = drain_q;
    pass_d    = pass_q;

    // A zero seed would lock the LFSR up, so it is replaced by 1.
    seed_in  = (Seed == '0) ? 32'h0000_0001 : Seed;
    load_val = SeedLoad ? seed_in : seed_q;
    start_ok = (state_q == ST_IDLE) && Start && !Abort;
    rx_ok    = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && RxValid &&
               (rx_cnt_q != len_q) && !Abort;

    if ((state_q == ST_IDLE) && SeedLoad) begin
      seed_d = seed_in;
    end

    if (rx_ok) begin
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
      if ((RxBit != chk_bit) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          len_d     = Length;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          err_cnt_d = '0;
          pass_d    = (Length == '0);
          state_d   = (Length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == len_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + DRAIN_W'(1);
        if ((rx_cnt_q == len_q) || (drain_q == DRAIN_W'(DRAIN_TO - 1))) begin
          state_d = ST_DONE;
          pass_d  = (err_cnt_d == '0) && (rx_cnt_d == len_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (Abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      seed_q    <= SEED_DEFAULT;
      len_q     <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      drain_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      len_q     <= len_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      drain_q   <= drain_d;
      pass_q    <= pass_d;
    end
  end

  prbs32_lfsr #(.RST_VAL(SEED_DEFAULT)) u_gen (
    .Clk     (Clk),
    .Rst     (Rst),
    .Load    (start_ok),
    .LoadVal (load_val),
    .Step    (state_q == ST_RUN),
    .Out     (gen_bit)
  );

  prbs32_lfsr #(.RST_VAL(SEED_DEFAULT)) u_chk (
    .Clk     (Clk),
    .Rst     (Rst),
    .Load    (start_ok),
    .LoadVal (load_val),
    .Step    (rx_ok),
    .Out     (chk_bit)
  );

  assign TxValid = (state_q == ST_RUN);
  assign TxBit   = TxValid & gen_bit;
  assign Busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign Done    = (state_q == ST_DONE);
  assign Pass    = pass_q;
  assign ErrCnt  = err_cnt_q;
  assign RxCnt   = rx_cnt_q;
endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Scoreboard bench for prbs_seq_ctrl: expected Tx bits and verdicts are queued at Start
// and compared as the DUT presents TxValid and Done.
module tb_prbs_seq_ctrl;
  localparam int CNT_W    = 16;
  localparam int DRAIN_TO = 64;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic             SeedLoad = 1'b0;
  logic [31:0]      Seed = '0;
  logic [CNT_W-1:0] Length = '0;
  logic             TxValid, TxBit, RxValid, RxBit, Busy, Done, Pass;
  logic [CNT_W-1:0] ErrCnt, RxCnt;

  typedef struct {
    logic pass;
    int   err;
    int   rx;
    int   lat;
    int   drain;
  } exp_t;

  exp_t        exp_q[$];
  logic        tx_q[$];
  exp_t        mon_e;
  int          vec_cnt = 0;
  int          miscmp  = 0;
  int          cyc = 0;
  int          t_start = 0;
  int          done_cnt = 0;
  int          drain_cyc = 0;
  int          tx_num = 0;
  logic        loop_en = 1'b0;
  int          inv_idx = -1;
  logic [31:0] seed_m = 32'h0000_0001;

  prbs_seq_ctrl #(.SEED_DEFAULT(32'h0000_0001), .CNT_W(CNT_W), .DRAIN_TO(DRAIN_TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .SeedLoad(SeedLoad),
    .Seed(Seed), .Length(Length), .TxValid(TxValid), .TxBit(TxBit),
    .RxValid(RxValid), .RxBit(RxBit), .Busy(Busy), .Done(Done), .Pass(Pass),
    .ErrCnt(ErrCnt), .RxCnt(RxCnt)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Zero-latency loopback with an optional single inverted bit.
  assign RxValid = loop_en & TxValid;
  assign RxBit   = TxBit ^ (tx_num == inv_idx);

  always @(posedge Clk) begin
    if (Start && !Busy && !Abort) tx_num <= 0;
    else if (TxValid) tx_num <= tx_num + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tb_step(input logic [31:0] s);
    logic [31:0] n;
    n[31]    = s[0];
    n[30:22] = s[31:23];
    n[21]    = s[0] ^ s[22];
    n[20:2]  = s[21:3];
    n[1]     = s[0] ^ s[2];
    n[0]     = s[0] ^ s[1];
    return n;
  endfunction

  always @(negedge Clk) begin
    if (TxValid) begin
      if (tx_q.size() > 0) check("tx_bit", TxBit, tx_q.pop_front());
      else check("tx_extra", 1, 0);
    end
    if (Busy && !TxValid) drain_cyc++;
    if (Done) begin
      done_cnt++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pass", Pass, mon_e.pass);
        check("err_cnt", ErrCnt, mon_e.err);
        check("rx_cnt", RxCnt, mon_e.rx);
        check("done_lat", cyc - t_start, mon_e.lat);
        check("drain_len", drain_cyc, mon_e.drain);
      end else begin
        check("done_extra", 1, 0);
      end
      drain_cyc = 0;
    end
  end

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge Clk);
      if (done_cnt != d0) break;
    end
    #1;
    check("done_timeout", (done_cnt != d0), 1);
  endtask

  task automatic run_test(input int len, input logic sl, input logic [31:0] sv,
                          input logic lp, input int inv, input logic restart);
    logic [31:0] s;
    exp_t        e;
    int          d0;
    @(posedge Clk); #1;
    if (sl) seed_m = (sv == 0) ? 32'h1 : sv;
    s = seed_m;
    for (int i = 0; i < len; i++) begin
      tx_q.push_back(s[0]);
      s = tb_step(s);
    end
    loop_en = lp;
    inv_idx = inv;
    e.pass  = (len == 0) ? 1'b1 : (lp && (inv < 0 || inv >= len));
    e.err   = (len > 0 && lp && inv >= 0 && inv < len) ? 1 : 0;
    e.rx    = lp ? len : 0;
    e.lat   = (len == 0) ? 1 : (lp ? len + 2 : len + 1 + DRAIN_TO);
    e.drain = (len == 0) ? 0 : (lp ? 1 : DRAIN_TO);
    exp_q.push_back(e);
    d0 = done_cnt;
    Start = 1'b1; SeedLoad = sl; Seed = sv; Length = CNT_W'(len);
    t_start = cyc;
    @(posedge Clk); #1;
    Start = 1'b0; SeedLoad = 1'b0;
    if (restart) begin
      repeat (2) @(posedge Clk);
      #1;
      Start = 1'b1; Length = CNT_W'(5);
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    wait_done(d0, len + DRAIN_TO + 20);
    @(posedge Clk); #1;
    check("tx_count", tx_num, len);
    check("idle_busy", Busy, 0);
    check("pass_hold", Pass, e.pass);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("rst_txvalid", TxValid, 0);
    check("rst_txbit", TxBit, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_pass", Pass, 0);
    check("rst_errcnt", ErrCnt, 0);
    check("rst_rxcnt", RxCnt, 0);

    run_test(3, 1'b1, 32'h1, 1'b1, -1, 1'b0);
    run_test(1000, 1'b0, 32'h0, 1'b1, 500, 1'b0);
    run_test(16, 1'b0, 32'h0, 1'b0, -1, 1'b0);
    run_test(20, 1'b1, 32'hACE1_2345, 1'b1, -1, 1'b0);

    @(posedge Clk); #1;
    SeedLoad = 1'b1; Seed = 32'h0; seed_m = 32'h1;
    @(posedge Clk); #1;
    SeedLoad = 1'b0;
    run_test(2, 1'b0, 32'h0, 1'b1, -1, 1'b0);

    run_test(8, 1'b0, 32'h0, 1'b1, -1, 1'b1);

    // Abort at t+5 of a 100-bit run: only five bits go out, no Done.
    @(posedge Clk); #1;
    begin
      logic [31:0] s;
      s = seed_m;
      for (int i = 0; i < 5; i++) begin
        tx_q.push_back(s[0]);
        s = tb_step(s);
      end
    end
    loop_en = 1'b0; inv_idx = -1;
    d0 = done_cnt;
    Start = 1'b1; Length = CNT_W'(100); t_start = cyc;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("abort_cycle", cyc - t_start, 5);
    Abort = 1'b1;
    @(posedge Clk); #1;
    Abort = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_txvalid", TxValid, 0);
    repeat (10) @(posedge Clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    check("abort_pass", Pass, 0);
    check("abort_tx_count", tx_num, 5);
    check("abort_rxcnt", RxCnt, 0);
    check("abort_txq_empty", tx_q.size(), 0);

    run_test(0, 1'b0, 32'h0, 1'b1, -1, 1'b0);

    repeat (3) @(posedge Clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule

// File: doc/prbs_seq_ctrl.md
# prbs_seq_ctrl

PRBS test sequencer that owns one generator LFSR and one checker LFSR (x^32 + x^22 + x^2 + x + 1, 32-bit Galois form) and runs a bounded bit-error test. It seeds both LFSRs, streams a programmed number of bits out, checks returning bits against the checker, and reports error and receive counts plus a pass/fail verdict. It sits between the host control registers and the serial loopback path of the PRBS datapath.

## Interface
- `SEED_DEFAULT`, 32'h0000_0001: seed register value after reset.
- `CNT_W`, 16: width of the length, transmit, receive and error counters.
- `DRAIN_TO`, 64: maximum number of cycles spent in DRAIN.
- `Clk`  in  1  single clock; all logic on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Start`  in  1  one-cycle request to begin a test; honoured in IDLE only.
- `Abort`  in  1  terminates any test and returns to IDLE.
- `SeedLoad`  in  1  writes `Seed` into the seed register; honoured in IDLE only.
- `Seed`  in  32  seed value.
- `Length`  in  CNT_W  number of bits to transmit; sampled on the accepted `Start`.
- `TxValid`  out  1  a transmit bit is presented this cycle.
- `TxBit`  out  1  generator bit 0.
- `RxValid`  in  1  a returned bit is present.
- `RxBit`  in  1  returned bit.
- `Busy`  out  1  state is RUN or DRAIN.
- `Done`  out  1  one-cycle completion pulse.
- `Pass`  out  1  verdict; valid from `Done` until the next accepted `Start`.
- `ErrCnt`  out  CNT_W  number of mismatches; saturates at all-ones.
- `RxCnt`  out  CNT_W  number of returned bits checked.

## Operation
- LFSR step for state s, used by both LFSRs:
  - n[31] = s[0]
  - n[30:22] = s[31:23]
  - n[21] = s[0]^s[22]
  - n[20:2] = s[21:3]
  - n[1] = s[0]^s[2]
  - n[0] = s[0]^s[1]
  - The output bit is s[0].
- Seed register: a `SeedLoad` of 0 stores 32'h1, which avoids the lock-up state.
- FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE → RUN on `Start` with `Length` != 0:
  - latch `Length`;
  - load the generator and checker from the seed register;
  - clear TxCnt, `RxCnt`, `ErrCnt` and `Pass`.
- IDLE → DONE on `Start` with `Length` == 0. No bits are sent and the verdict is `Pass`=1.
- RUN, each cycle:
  - `TxValid`=1 and `TxBit`=gen[0];
  - the generator steps;
  - TxCnt increments.
  - On the cycle with TxCnt == Length-1, the next state is DRAIN.
- Receive checking, in RUN and DRAIN only: on `RxValid`, compare `RxBit` with chk[0].
  - A mismatch increments `ErrCnt`, saturating.
  - The checker steps.
  - `RxCnt` increments.
  - `RxValid` is ignored in IDLE and DONE, and once `RxCnt` == Length.
- DRAIN → DONE when `RxCnt` == Length, or after `DRAIN_TO` cycles in DRAIN, whichever comes first.
- DONE:
  - `Done`=1 for one cycle;
  - `Pass` = (`ErrCnt` == 0) && (`RxCnt` == Length);
  - next state is IDLE.
- `Abort` in RUN, DRAIN or DONE forces IDLE next cycle.
  - No `Done` pulse.
  - `Pass` = 0.
  - Counters hold their values.
- `Start` and `Abort` in the same cycle: `Abort` wins.
- `Start` and `SeedLoad` in the same IDLE cycle: the new `Seed` is used for this test.
- `Start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - seed register = `SEED_DEFAULT`;
  - `TxValid`, `TxBit`, `Busy`, `Done`, `Pass`, `ErrCnt`, `RxCnt` all 0;
  - both LFSRs = `SEED_DEFAULT`.
- Start accepted at cycle t:
  - `Busy` and `TxValid` are 1 from t+1 through t+Length.
  - The first `TxBit` is seed[0].
  - All outputs are registered.
- An Rx sample at cycle k updates `ErrCnt` and `RxCnt` at k+1.
- On the final receive, DRAIN is left one cycle after `RxCnt` reaches Length.
  - `Done` follows one cycle after that.
  - Zero-latency loopback: `Done` at t+Length+2.
- Length == 0: `Done` at t+1, `Busy` never asserted.
- `Rst` takes effect mid-test on the next edge, regardless of state.

## Structure
- Shared package `prbs_pkg`:
  - FSM state enum;
  - POLY_TAPS constant;
  - LFSR width 32;
  - default seed.
- Sub-module `prbs32_lfsr`: 32-bit register with `Load`/`LoadVal`/`Step` and output s[0], implementing the step above. Instantiate it twice, once as generator and once as checker.
- The controller holds the FSM, the seed register, the counters and the drain timer.

## Test plan
- Reset, then seed 1, Length=3, TxBit looped to RxBit at zero latency:
  - TxBit sequence is 1, 1, 0;
  - generator states are 0x00000001, 0x80200003, 0xC0300002;
  - `Done` arrives at t+5 with `Pass`=1, `ErrCnt`=0, `RxCnt`=3.
- Length=1000 looped back with bit 500 inverted → `ErrCnt`=1, `Pass`=0, `RxCnt`=1000.
- Length=16 with no `RxValid` → DRAIN lasts exactly 64 cycles, then `Done` with `Pass`=0, `RxCnt`=0.
- `SeedLoad` of 0, then Length=2 → first TxBits are 1, 1, the same as seed 1.
- `Abort` at cycle t+5 of a Length=100 run:
  - IDLE at t+6;
  - `TxValid` is 0 from t+6;
  - no `Done`, `Pass`=0.
- `Start` with Length=0 → `Done` at t+1, `Pass`=1, `TxValid` never 1. `Start` during RUN is ignored: TxValid count stays at `Length`.
